// File: rtl/uart_tx.sv
// UART transmitter clocked at the bit rate: start bit, LSB-first data, optional parity, stop bit.
// Define UART_TX_PARITY_EN to compile in the parity bit; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic par_bit;

    assign par_bit = (^data_q) ^ par_typ_q;
`else
    logic unused_par_inputs;
    assign unused_par_inputs = PAR_EN | PAR_TYP;
`endif

    // Outputs are computed for the state being entered so TX_OUT/busy are plain flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif
        case (state_q)
            // The edge ending the stop bit may accept the next word: no idle gap.
            S_IDLE, S_STOP: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                if (Data_valid) begin
                    state_d = S_START;
                    data_d  = P_DATA;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
`endif
                end
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
                tx_d    = data_q[0];
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    if (par_en_q) begin
                        state_d = S_PARITY;
                        tx_d    = par_bit;
                    end else begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
`else
                    state_d = S_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    tx_d  = data_q[cnt_d];
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
`endif
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized frames against a frame-list model.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line levels for one frame, one entry per bit period.
    function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt,
                                        output logic bits[$]);
        int ones;
        bits = {};
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (PAR_ON && pe) begin
            if (pt == 1'b0) bits.push_back(logic'(ones % 2));
            else            bits.push_back(logic'(1 - (ones % 2)));
        end
        bits.push_back(1'b1);
    endfunction

    // mode: 0 plain, 1 change inputs mid-frame, 2 stray Data_valid during bit 3,
    //       3 chain next word (nd) at the stop edge, 4 reset during bit 5.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input int mode, input bit skip_start, input logic [7:0] nd);
        logic exp_bits[$];
        int   len;
        if (!skip_start) begin
            @(negedge CLK);
            P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_valid = 1'b1;
            @(posedge CLK); #1;
            Data_valid = 1'b0;
        end
        build_frame(d, pe, pt, exp_bits);
        len = exp_bits.size();
        for (int i = 0; i < len; i++) begin
            chk($sformatf("tx[%0d] d=%02h", i, d), {31'd0, TX_OUT}, {31'd0, exp_bits[i]});
            chk($sformatf("busy[%0d] d=%02h", i, d), {31'd0, busy}, 32'd1);
            if (mode == 1 && i == 3) begin
                P_DATA = 8'h00; PAR_EN = ~pe; PAR_TYP = ~pt;
            end
            if (mode == 2 && i == 4) Data_valid = 1'b1;
            if (mode == 2 && i == 5) Data_valid = 1'b0;
            if (mode == 3 && i == len - 1) begin
                P_DATA = nd; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_valid = 1'b1;
            end
            if (mode == 4 && i == 6) begin
                #1 RST = 1'b1;
                #1;
                chk("rst_async_tx", {31'd0, TX_OUT}, 32'd1);
                chk("rst_async_busy", {31'd0, busy}, 32'd0);
                @(posedge CLK); #1;
                chk("rst_hold_busy", {31'd0, busy}, 32'd0);
                @(negedge CLK);
                RST = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        if (mode == 3) begin
            Data_valid = 1'b0;
            return;
        end
        chk($sformatf("idle_tx d=%02h", d), {31'd0, TX_OUT}, 32'd1);
        chk($sformatf("idle_busy d=%02h", d), {31'd0, busy}, 32'd0);
        if (mode == 2) begin
            repeat (3) begin
                @(posedge CLK); #1;
                chk("no_queued_frame_busy", {31'd0, busy}, 32'd0);
                chk("no_queued_frame_tx", {31'd0, TX_OUT}, 32'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, carry;
        logic       pe, pt;
        bit         chained;
        RST = 1'b0; Data_valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_reset_tx", {31'd0, TX_OUT}, 32'd1);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        run_frame(8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        run_frame(8'h01, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        run_frame(8'hFF, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        run_frame(8'hAB, 1'b0, 1'b0, 1, 1'b0, 8'h00);
        run_frame(8'h48, 1'b1, 1'b0, 0, 1'b0, 8'h00);
        run_frame(8'h48, 1'b1, 1'b1, 0, 1'b0, 8'h00);
        run_frame(8'hC3, 1'b1, 1'b1, 1, 1'b0, 8'h00);
        run_frame(8'h96, 1'b0, 1'b0, 2, 1'b0, 8'h00);
        run_frame(8'h3C, 1'b1, 1'b0, 3, 1'b0, 8'hE7);
        run_frame(8'hE7, 1'b0, 1'b0, 0, 1'b1, 8'h00);
        run_frame(8'h77, 1'b0, 1'b0, 4, 1'b0, 8'h00);
        run_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0, 8'h00);

        chained = 1'b0;
        carry   = 8'h00;
        for (int k = 0; k < 30; k++) begin
            if (chained) begin
                d = carry; pe = 1'b0; pt = 1'b0;
            end else begin
                d  = 8'($urandom);
                pe = 1'($urandom);
                pt = 1'($urandom);
            end
            if ($urandom_range(0, 3) == 0 && k < 29) begin
                carry = 8'($urandom);
                run_frame(d, pe, pt, 3, chained, carry);
                chained = 1'b1;
            end else begin
                run_frame(d, pe, pt, 0, chained, 8'h00);
                chained = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
